// File: rtl/mby_igr_pb_bank_arb.sv
// Per-bank PB arbiter: write priority capped by STARVE_LIM, round-robin reads, 1-cycle shell/response latency, reads back-pressured at MAX_OUT.
// Optional MBY_IGR_PB_ARB_PERF_EN adds per-bank grant/starvation counters; flat rd buses index requester-major [(r*PB_BANKS+b)*W +: W].
module mby_igr_pb_bank_arb #(
   parameter int PB_BANKS   = 4,
   parameter int NUM_RD     = 2,
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 644,
   parameter int TAG_W      = 4,
   parameter int MAX_OUT    = 4,
   parameter int STARVE_LIM = 8,
   localparam int ID_W      = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
   input  logic                                cclk,
   input  logic                                rst_b,
   input  logic [PB_BANKS-1:0]                 i_wr_vld,
   input  logic [PB_BANKS*ADDR_W-1:0]          i_wr_adr,
   input  logic [PB_BANKS*DATA_W-1:0]          i_wr_data,
   output logic [PB_BANKS-1:0]                 o_wr_rdy,
   input  logic [NUM_RD*PB_BANKS-1:0]          i_rd_vld,
   input  logic [NUM_RD*PB_BANKS*ADDR_W-1:0]   i_rd_adr,
   input  logic [NUM_RD*PB_BANKS*TAG_W-1:0]    i_rd_tag,
   output logic [NUM_RD*PB_BANKS-1:0]          o_rd_rdy,
   output logic [PB_BANKS*ADDR_W-1:0]          o_shell_adr,
   output logic [PB_BANKS-1:0]                 o_shell_rd_en,
   output logic [PB_BANKS-1:0]                 o_shell_wr_en,
   output logic [PB_BANKS*DATA_W-1:0]          o_shell_wr_data,
   input  logic [PB_BANKS-1:0]                 i_shell_rd_valid,
   input  logic [PB_BANKS*DATA_W-1:0]          i_shell_rd_data,
   output logic [PB_BANKS-1:0]                 o_rsp_vld,
   output logic [PB_BANKS*ID_W-1:0]            o_rsp_req_id,
   output logic [PB_BANKS*TAG_W-1:0]           o_rsp_tag,
   output logic [PB_BANKS*DATA_W-1:0]          o_rsp_data,
`ifdef MBY_IGR_PB_ARB_PERF_EN
   output logic [PB_BANKS*32-1:0]              o_perf_wr_cnt,
   output logic [PB_BANKS*32-1:0]              o_perf_rd_cnt,
   output logic [PB_BANKS*32-1:0]              o_perf_starve_cnt,
`endif
   output logic [PB_BANKS-1:0]                 o_err_unexp_rd
);

   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int SC_W  = $clog2(STARVE_LIM + 1);
   localparam int ENT_W = ID_W + TAG_W;

   for (genvar b = 0; b < PB_BANKS; b++) begin : g_bank
      logic [NUM_RD-1:0] rd_vld_b;
      logic              rd_pend, wr_gnt, rd_gnt, found, fifo_empty, pop;
      logic [ID_W-1:0]   rd_sel, idx;
      logic [ADDR_W-1:0] rd_adr;
      logic [TAG_W-1:0]  rd_tag;
      logic [ID_W-1:0]   ptr_q, ptr_d;
      logic [SC_W-1:0]   starve_q, starve_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
      logic [ENT_W-1:0]  mem_q [MAX_OUT];
      logic [ENT_W-1:0]  mem_d [MAX_OUT];
      logic [ADDR_W-1:0] adr_q, adr_d;
      logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
      logic [DATA_W-1:0] wdat_q, wdat_d;
      logic              rsp_vld_q, rsp_vld_d, err_q, err_d;
      logic [ENT_W-1:0]  rsp_ent_q, rsp_ent_d;
      logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;

      for (genvar r = 0; r < NUM_RD; r++) begin : g_req
         assign rd_vld_b[r] = i_rd_vld[r*PB_BANKS+b];
         assign o_rd_rdy[r*PB_BANKS+b] = rd_gnt && (rd_sel == ID_W'(r));
      end

      // Round-robin scan starts at the requester after the last one granted.
      always_comb begin
         rd_sel = '0;
         idx    = '0;
         found  = 1'b0;
         for (int k = 0; k < NUM_RD; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_RD);
            if (!found && rd_vld_b[idx]) begin
               found  = 1'b1;
               rd_sel = idx;
            end
         end
         rd_pend = (|rd_vld_b) && (cnt_q < CNT_W'(MAX_OUT));
         wr_gnt  = rst_b && i_wr_vld[b] && !(rd_pend && (starve_q == SC_W'(STARVE_LIM)));
         rd_gnt  = rst_b && !wr_gnt && rd_pend;
      end

      assign rd_adr     = i_rd_adr[(int'(rd_sel)*PB_BANKS+b)*ADDR_W +: ADDR_W];
      assign rd_tag     = i_rd_tag[(int'(rd_sel)*PB_BANKS+b)*TAG_W +: TAG_W];
      assign fifo_empty = (cnt_q == '0);
      assign pop        = i_shell_rd_valid[b] && !fifo_empty;

      always_comb begin
         ptr_d = ptr_q;
         if (rd_gnt) ptr_d = (int'(rd_sel) == NUM_RD - 1) ? '0 : rd_sel + ID_W'(1);
         starve_d = starve_q;
         if (rd_gnt || !rd_pend) starve_d = '0;
         else if (wr_gnt && (starve_q != SC_W'(STARVE_LIM))) starve_d = starve_q + SC_W'(1);
         wr_en_d = wr_gnt;
         rd_en_d = rd_gnt;
         adr_d   = adr_q;
         wdat_d  = wdat_q;
         if (wr_gnt) begin
            adr_d  = i_wr_adr[b*ADDR_W +: ADDR_W];
            wdat_d = i_wr_data[b*DATA_W +: DATA_W];
         end else if (rd_gnt) begin
            adr_d  = rd_adr;
         end
         mem_d  = mem_q;
         wptr_d = wptr_q;
         rptr_d = rptr_q;
         if (rd_gnt) begin
            mem_d[wptr_q] = {rd_sel, rd_tag};
            wptr_d        = wptr_q + PTR_W'(1);
         end
         if (pop) rptr_d = rptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(rd_gnt) - CNT_W'(pop);
         // A response with no matching outstanding read carries id/tag 0.
         rsp_vld_d = i_shell_rd_valid[b];
         rsp_ent_d = rsp_ent_q;
         rsp_dat_d = rsp_dat_q;
         if (i_shell_rd_valid[b]) begin
            rsp_dat_d = i_shell_rd_data[b*DATA_W +: DATA_W];
            rsp_ent_d = fifo_empty ? '0 : mem_q[rptr_q];
         end
         err_d = err_q || (i_shell_rd_valid[b] && fifo_empty);
      end

      always_ff @(posedge cclk or negedge rst_b) begin
         if (!rst_b) begin
            ptr_q     <= '0;
            starve_q  <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            for (int i = 0; i < MAX_OUT; i++) mem_q[i] <= '0;
            adr_q     <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wdat_q    <= '0;
            rsp_vld_q <= 1'b0;
            rsp_ent_q <= '0;
            rsp_dat_q <= '0;
            err_q     <= 1'b0;
         end else begin
            ptr_q     <= ptr_d;
            starve_q  <= starve_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_q     <= mem_d;
            adr_q     <= adr_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            wdat_q    <= wdat_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_ent_q <= rsp_ent_d;
            rsp_dat_q <= rsp_dat_d;
            err_q     <= err_d;
         end
      end

      assign o_wr_rdy[b]                        = wr_gnt;
      assign o_shell_adr[b*ADDR_W +: ADDR_W]    = adr_q;
      assign o_shell_rd_en[b]                   = rd_en_q;
      assign o_shell_wr_en[b]                   = wr_en_q;
      assign o_shell_wr_data[b*DATA_W +: DATA_W] = wdat_q;
      assign o_rsp_vld[b]                       = rsp_vld_q;
      assign o_rsp_req_id[b*ID_W +: ID_W]       = rsp_ent_q[ENT_W-1 -: ID_W];
      assign o_rsp_tag[b*TAG_W +: TAG_W]        = rsp_ent_q[TAG_W-1:0];
      assign o_rsp_data[b*DATA_W +: DATA_W]     = rsp_dat_q;
      assign o_err_unexp_rd[b]                  = err_q;

`ifdef MBY_IGR_PB_ARB_PERF_EN
      logic [31:0] pwr_q, pwr_d, prd_q, prd_d, pst_q, pst_d;
      // A forced read is a read grant taken while a write was also asking.
      always_comb begin
         pwr_d = (wr_gnt && (pwr_q != '1)) ? pwr_q + 32'd1 : pwr_q;
         prd_d = (rd_gnt && (prd_q != '1)) ? prd_q + 32'd1 : prd_q;
         pst_d = (rd_gnt && i_wr_vld[b] && (pst_q != '1)) ? pst_q + 32'd1 : pst_q;
      end
      always_ff @(posedge cclk or negedge rst_b) begin
         if (!rst_b) begin
            pwr_q <= '0;
            prd_q <= '0;
            pst_q <= '0;
         end else begin
            pwr_q <= pwr_d;
            prd_q <= prd_d;
            pst_q <= pst_d;
         end
      end
      assign o_perf_wr_cnt[b*32 +: 32]     = pwr_q;
      assign o_perf_rd_cnt[b*32 +: 32]     = prd_q;
      assign o_perf_starve_cnt[b*32 +: 32] = pst_q;
`endif
   end

endmodule

// File: tb/tb_mby_igr_pb_bank_arb.sv
// Directed bench for mby_igr_pb_bank_arb: arbitration vector table plus hand-written datapath, FIFO, error and reset sequences.
module tb_mby_igr_pb_bank_arb;
   localparam int PB_BANKS = 4, NUM_RD = 2, ADDR_W = 10, DATA_W = 644, TAG_W = 4;
   localparam int MAX_OUT = 4, STARVE_LIM = 8, ID_W = 1;

   logic                              cclk = 1'b0;
   logic                              rst_b;
   logic [PB_BANKS-1:0]               i_wr_vld;
   logic [PB_BANKS*ADDR_W-1:0]        i_wr_adr;
   logic [PB_BANKS*DATA_W-1:0]        i_wr_data;
   logic [PB_BANKS-1:0]               o_wr_rdy;
   logic [NUM_RD*PB_BANKS-1:0]        i_rd_vld;
   logic [NUM_RD*PB_BANKS*ADDR_W-1:0] i_rd_adr;
   logic [NUM_RD*PB_BANKS*TAG_W-1:0]  i_rd_tag;
   logic [NUM_RD*PB_BANKS-1:0]        o_rd_rdy;
   logic [PB_BANKS*ADDR_W-1:0]        o_shell_adr;
   logic [PB_BANKS-1:0]               o_shell_rd_en, o_shell_wr_en;
   logic [PB_BANKS*DATA_W-1:0]        o_shell_wr_data;
   logic [PB_BANKS-1:0]               i_shell_rd_valid;
   logic [PB_BANKS*DATA_W-1:0]        i_shell_rd_data;
   logic [PB_BANKS-1:0]               o_rsp_vld;
   logic [PB_BANKS*ID_W-1:0]          o_rsp_req_id;
   logic [PB_BANKS*TAG_W-1:0]         o_rsp_tag;
   logic [PB_BANKS*DATA_W-1:0]        o_rsp_data;
   logic [PB_BANKS-1:0]               o_err_unexp_rd;
`ifdef MBY_IGR_PB_ARB_PERF_EN
   logic [PB_BANKS*32-1:0]            o_perf_wr_cnt, o_perf_rd_cnt, o_perf_starve_cnt;
`endif

   mby_igr_pb_bank_arb #(
      .PB_BANKS(PB_BANKS), .NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .TAG_W(TAG_W), .MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .cclk(cclk), .rst_b(rst_b),
      .i_wr_vld(i_wr_vld), .i_wr_adr(i_wr_adr), .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy),
      .i_rd_vld(i_rd_vld), .i_rd_adr(i_rd_adr), .i_rd_tag(i_rd_tag), .o_rd_rdy(o_rd_rdy),
      .o_shell_adr(o_shell_adr), .o_shell_rd_en(o_shell_rd_en), .o_shell_wr_en(o_shell_wr_en),
      .o_shell_wr_data(o_shell_wr_data), .i_shell_rd_valid(i_shell_rd_valid),
      .i_shell_rd_data(i_shell_rd_data), .o_rsp_vld(o_rsp_vld), .o_rsp_req_id(o_rsp_req_id),
      .o_rsp_tag(o_rsp_tag), .o_rsp_data(o_rsp_data),
`ifdef MBY_IGR_PB_ARB_PERF_EN
      .o_perf_wr_cnt(o_perf_wr_cnt), .o_perf_rd_cnt(o_perf_rd_cnt),
      .o_perf_starve_cnt(o_perf_starve_cnt),
`endif
      .o_err_unexp_rd(o_err_unexp_rd)
   );

   always #5 cclk = ~cclk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] wr_vld;
      logic [7:0] rd_vld;
      logic [3:0] rd_valid;
      logic [3:0] exp_wr_rdy;
      logic [7:0] exp_rd_rdy;
   } vec_t;
   vec_t vec [20];

   task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge cclk);
      #1;
   endtask

   task automatic idle_in();
      i_wr_vld = '0; i_wr_adr = '0; i_wr_data = '0;
      i_rd_vld = '0; i_rd_adr = '0; i_rd_tag = '0;
      i_shell_rd_valid = '0; i_shell_rd_data = '0;
   endtask

   task automatic set_rd(input int r, input int b, input logic v, input logic [9:0] adr, input logic [3:0] tag);
      i_rd_vld[r*PB_BANKS+b] = v;
      i_rd_adr[(r*PB_BANKS+b)*ADDR_W +: ADDR_W] = adr;
      i_rd_tag[(r*PB_BANKS+b)*TAG_W +: TAG_W] = tag;
   endtask

   task automatic do_reset();
      idle_in();
      rst_b = 1'b0;
      step();
      step();
      rst_b = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      logic [DATA_W-1:0] d1, d2, d3;
      logic [3:0] etag [4];
      logic       eid  [4];
      d1 = {161{4'hA}}; d1[31:0] = 32'h1234_5678;
      d2 = {161{4'h3}}; d2[15:0] = 16'hBEEF;
      d3 = {161{4'hC}}; d3[7:0]  = 8'h5A;
      etag = '{4'd2, 4'd3, 4'd4, 4'd5};
      eid  = '{1'b1, 1'b0, 1'b1, 1'b0};

      // Bank1: write vs read starvation; bank2: two requesters alternate until 4 outstanding.
      vec[0]  = '{4'b0010, 8'h46, 4'h0, 4'b0010, 8'h04};
      vec[1]  = '{4'b0010, 8'h46, 4'h0, 4'b0010, 8'h40};
      vec[2]  = '{4'b0010, 8'h46, 4'h0, 4'b0010, 8'h04};
      vec[3]  = '{4'b0010, 8'h46, 4'h0, 4'b0010, 8'h40};
      vec[4]  = '{4'b0010, 8'h46, 4'h0, 4'b0010, 8'h00};
      vec[5]  = '{4'b0010, 8'h46, 4'h0, 4'b0010, 8'h00};
      vec[6]  = '{4'b0010, 8'h46, 4'h4, 4'b0010, 8'h00};
      vec[7]  = '{4'b0010, 8'h46, 4'h0, 4'b0010, 8'h04};
      vec[8]  = '{4'b0010, 8'h02, 4'h0, 4'b0000, 8'h02};
      for (int i = 9; i < 20; i++) vec[i] = '{4'b0010, 8'h02, 4'h0, 4'b0010, 8'h00};
      vec[17] = '{4'b0010, 8'h02, 4'h0, 4'b0000, 8'h02};

      idle_in();
      rst_b = 1'b0;
      #1;
      chk("reset wr_rdy", o_wr_rdy, '0);
      step();
      chk("reset shell_en", {o_shell_rd_en, o_shell_wr_en}, '0);
      chk("reset shell_adr", o_shell_adr, '0);
      chk("reset rsp_vld", o_rsp_vld, '0);
      chk("reset err", o_err_unexp_rd, '0);
      step();
      rst_b = 1'b1;
      i_wr_vld = 4'hF; i_rd_vld = 8'hFF;
      rst_b = 1'b0;
      #1;
      chk("reset rdy gated", {o_wr_rdy, o_rd_rdy}, '0);
      do_reset();

      for (int i = 0; i < 20; i++) begin
         i_wr_vld = vec[i].wr_vld;
         i_rd_vld = vec[i].rd_vld;
         i_shell_rd_valid = vec[i].rd_valid;
         #1;
         chk($sformatf("tbl%0d wr_rdy", i), o_wr_rdy, vec[i].exp_wr_rdy);
         chk($sformatf("tbl%0d rd_rdy", i), o_rd_rdy, vec[i].exp_rd_rdy);
         step();
         chk($sformatf("tbl%0d shell_wr_en", i), o_shell_wr_en, vec[i].exp_wr_rdy);
         chk($sformatf("tbl%0d shell_rd_en", i), o_shell_rd_en, vec[i].exp_rd_rdy[3:0] | vec[i].exp_rd_rdy[7:4]);
      end

      // Write then read back on bank0.
      do_reset();
      i_wr_vld[0] = 1'b1; i_wr_adr[9:0] = 10'h3A5; i_wr_data[DATA_W-1:0] = d1;
      #1;
      chk("s1 wr_rdy", o_wr_rdy[0], 1'b1);
      step();
      idle_in();
      chk("s1 shell_wr_en", o_shell_wr_en[0], 1'b1);
      chk("s1 shell_rd_en", o_shell_rd_en[0], 1'b0);
      chk("s1 shell_adr", o_shell_adr[9:0], 10'h3A5);
      chk("s1 shell_wr_data", o_shell_wr_data[DATA_W-1:0], d1);
      step();
      chk("s1 idle wr_en", o_shell_wr_en[0], 1'b0);
      chk("s1 idle adr hold", o_shell_adr[9:0], 10'h3A5);
      set_rd(0, 0, 1'b1, 10'h3A5, 4'd5);
      #1;
      chk("s1 rd_rdy", o_rd_rdy[0], 1'b1);
      step();
      set_rd(0, 0, 1'b0, 10'h0, 4'd0);
      chk("s1 shell_rd_en", o_shell_rd_en[0], 1'b1);
      chk("s1 rd adr", o_shell_adr[9:0], 10'h3A5);
      step();
      i_shell_rd_valid[0] = 1'b1; i_shell_rd_data[DATA_W-1:0] = d1;
      step();
      i_shell_rd_valid = '0;
      chk("s1 rsp_vld", o_rsp_vld[0], 1'b1);
      chk("s1 rsp_id", o_rsp_req_id[0], 1'b0);
      chk("s1 rsp_tag", o_rsp_tag[3:0], 4'd5);
      chk("s1 rsp_data", o_rsp_data[DATA_W-1:0], d1);
      step();
      chk("s1 rsp_vld drop", o_rsp_vld[0], 1'b0);

      // Bank2: push and pop together at count 3, then full-FIFO back-pressure.
      set_rd(0, 2, 1'b1, 10'h010, 4'd1); #1; chk("s2 g1", o_rd_rdy[2], 1'b1); step(); set_rd(0, 2, 1'b0, 10'h0, 4'd0);
      set_rd(1, 2, 1'b1, 10'h011, 4'd2); #1; chk("s2 g2", o_rd_rdy[6], 1'b1); step(); set_rd(1, 2, 1'b0, 10'h0, 4'd0);
      set_rd(0, 2, 1'b1, 10'h012, 4'd3); #1; chk("s2 g3", o_rd_rdy[2], 1'b1); step(); set_rd(0, 2, 1'b0, 10'h0, 4'd0);
      set_rd(1, 2, 1'b1, 10'h013, 4'd4);
      i_shell_rd_valid[2] = 1'b1; i_shell_rd_data[2*DATA_W +: DATA_W] = d2;
      #1;
      chk("s2 push+pop rdy", o_rd_rdy[6], 1'b1);
      step();
      set_rd(1, 2, 1'b0, 10'h0, 4'd0); i_shell_rd_valid = '0;
      chk("s2 pop rsp_vld", o_rsp_vld[2], 1'b1);
      chk("s2 pop rsp_id", o_rsp_req_id[2], 1'b0);
      chk("s2 pop rsp_tag", o_rsp_tag[8 +: 4], 4'd1);
      chk("s2 pop rsp_data", o_rsp_data[2*DATA_W +: DATA_W], d2);
      set_rd(0, 2, 1'b1, 10'h014, 4'd5); #1; chk("s2 4th slot", o_rd_rdy[2], 1'b1); step(); set_rd(0, 2, 1'b0, 10'h0, 4'd0);
      set_rd(1, 2, 1'b1, 10'h015, 4'd6); i_wr_vld[2] = 1'b1;
      #1;
      chk("s2 full rd_rdy", o_rd_rdy[6], 1'b0);
      chk("s2 full wr_rdy", o_wr_rdy[2], 1'b1);
      step();
      idle_in();
      chk("s2 full shell_wr_en", o_shell_wr_en[2], 1'b1);
      i_shell_rd_valid[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("s2 order%0d tag", k), o_rsp_tag[8 +: 4], etag[k]);
         chk($sformatf("s2 order%0d id", k), o_rsp_req_id[2], eid[k]);
      end
      i_shell_rd_valid = '0;
      chk("s2 err clean", o_err_unexp_rd[2], 1'b0);

      // Bank3: legitimate response first so a stale id/tag would show.
      set_rd(1, 3, 1'b1, 10'h020, 4'hC); #1; chk("s3 rd_rdy", o_rd_rdy[7], 1'b1); step(); set_rd(1, 3, 1'b0, 10'h0, 4'd0);
      i_shell_rd_valid[3] = 1'b1; step(); i_shell_rd_valid = '0;
      chk("s3 ok tag", o_rsp_tag[12 +: 4], 4'hC);
      chk("s3 ok id", o_rsp_req_id[3], 1'b1);
      chk("s3 ok err", o_err_unexp_rd[3], 1'b0);
      i_shell_rd_valid[3] = 1'b1; i_shell_rd_data[3*DATA_W +: DATA_W] = d3;
      step();
      i_shell_rd_valid = '0;
      chk("s3 unexp rsp_vld", o_rsp_vld[3], 1'b1);
      chk("s3 unexp id", o_rsp_req_id[3], 1'b0);
      chk("s3 unexp tag", o_rsp_tag[12 +: 4], 4'h0);
      chk("s3 unexp data", o_rsp_data[3*DATA_W +: DATA_W], d3);
      chk("s3 unexp err", o_err_unexp_rd, 4'b1000);
      step(); step();
      chk("s3 err sticky", o_err_unexp_rd[3], 1'b1);

      // Bank0: reset with three reads outstanding.
      for (int k = 0; k < 3; k++) begin
         set_rd(0, 0, 1'b1, 10'(k + 1), 4'(7 + k));
         #1;
         chk($sformatf("s4 rd%0d rdy", k), o_rd_rdy[0], 1'b1);
         step();
      end
      set_rd(0, 0, 1'b0, 10'h0, 4'd0);
      i_wr_vld[1] = 1'b1; i_wr_adr[10 +: 10] = 10'h155;
      step();
      chk("s4 pre wr_en", o_shell_wr_en[1], 1'b1);
      rst_b = 1'b0;
      #1;
      chk("s4 rst wr_rdy", o_wr_rdy, '0);
      chk("s4 rst shell_en", {o_shell_rd_en, o_shell_wr_en}, '0);
      chk("s4 rst shell_adr", o_shell_adr, '0);
      chk("s4 rst rsp_data", o_rsp_data, '0);
      chk("s4 rst err", o_err_unexp_rd, '0);
      idle_in();
      step();
      rst_b = 1'b1;
      step();
      i_shell_rd_valid[0] = 1'b1;
      step();
      i_shell_rd_valid = '0;
      chk("s4 post err", o_err_unexp_rd, 4'b0001);
      chk("s4 post tag", o_rsp_tag[3:0], 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
